hilo_ctrl: RTL and testbench

//  Sequencer and HI/LO register pair sitting directly downstream of the iterative

---
 rtl/hilo_ctrl.sv | 110 +++++++++++
 tb/tb_hilo_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/hilo_ctrl.sv
// HI/LO register pair and launch/commit sequencer for the iterative mult and divider.
// Launches a unit by pulsing its reset, waits its fixed latency, then commits its HI/LO.
module hilo_ctrl #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 32,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_start,
  input  logic             op_sel,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic [WIDTH-1:0] unit_a,
  output logic [WIDTH-1:0] unit_b,
  output logic             mult_rst,
  output logic             div_rst,
  input  logic [WIDTH-1:0] mult_hi,
  input  logic [WIDTH-1:0] mult_lo,
  input  logic [WIDTH-1:0] div_hi,
  input  logic [WIDTH-1:0] div_lo,
  input  logic             mthi_we,
  input  logic             mtlo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             done,
  output logic             div0_exc
);

  // Handshake: op_start/mthi_we/mtlo_we are accepted only on a cycle where busy is low;
  // while busy is high the requester must hold off, anything presented is dropped.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_RUN    = 3'd2,
    S_COMMIT = 3'd3,
    S_EXC    = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] last_cnt;
  logic             sel;
  logic             accept;

  assign accept   = (state == S_IDLE) && op_start;
  assign last_cnt = sel ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (op_start) state_nx = (op_sel && (rt_val == '0)) ? S_EXC : S_LAUNCH;
      S_LAUNCH: state_nx = S_RUN;
      S_RUN:    if (cnt == last_cnt) state_nx = S_COMMIT;
      S_COMMIT: state_nx = S_IDLE;
      S_EXC:    state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  cnt <= '0;
    else if (state == S_LAUNCH) cnt <= '0;
    else if (state == S_RUN)    cnt <= cnt + 1'b1;
  end

  // Operands are captured once at acceptance and held until the next accepted op.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      unit_a <= '0;
      unit_b <= '0;
      sel    <= 1'b0;
    end else if (accept) begin
      unit_a <= rs_val;
      unit_b <= rt_val;
      sel    <= op_sel;
    end
  end

  // A launch in the same cycle as mthi/mtlo takes priority and the writes are lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_out <= '0;
      lo_out <= '0;
    end else if (state == S_COMMIT) begin
      hi_out <= sel ? div_hi : mult_hi;
      lo_out <= sel ? div_lo : mult_lo;
    end else if ((state == S_IDLE) && !op_start) begin
      if (mthi_we) hi_out <= wdata;
      if (mtlo_we) lo_out <= wdata;
    end
  end

  assign busy     = (state != S_IDLE);
  assign done     = (state == S_COMMIT);
  assign div0_exc = (state == S_EXC);
  // Both units are held in reset while the block itself is in reset.
  assign mult_rst = reset | ((state == S_LAUNCH) & ~sel);
  assign div_rst  = reset | ((state == S_LAUNCH) & sel);

endmodule

// File: tb/tb_hilo_ctrl.sv
// Self-checking bench for hilo_ctrl: behavioural mult/div unit models, randomized ops,
// expected HI/LO kept in a queue and checked after each commit.
module tb_hilo_ctrl;
  localparam int W  = 32;
  localparam int MC = 32;
  localparam int DC = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         op_start = 1'b0, op_sel = 1'b0, mthi_we = 1'b0, mtlo_we = 1'b0;
  logic [W-1:0] rs_val = '0, rt_val = '0, wdata = '0;
  logic [W-1:0] mult_hi, mult_lo, div_hi, div_lo;
  logic [W-1:0] unit_a, unit_b, hi_out, lo_out;
  logic         mult_rst, div_rst, busy, done, div0_exc;

  int n_checks = 0;
  int n_pass   = 0;
  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]   exp_hi = '0;
  logic [W-1:0]   exp_lo = '0;

  // clock / reset
  always #5 clk = ~clk;

  hilo_ctrl #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .op_start(op_start), .op_sel(op_sel),
    .rs_val(rs_val), .rt_val(rt_val), .unit_a(unit_a), .unit_b(unit_b),
    .mult_rst(mult_rst), .div_rst(div_rst), .mult_hi(mult_hi), .mult_lo(mult_lo),
    .div_hi(div_hi), .div_lo(div_lo), .mthi_we(mthi_we), .mtlo_we(mtlo_we),
    .wdata(wdata), .hi_out(hi_out), .lo_out(lo_out), .busy(busy), .done(done),
    .div0_exc(div0_exc)
  );

  function automatic logic [63:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return sa * sb;
  endfunction

  // Returns {remainder, quotient}, signed semantics.
  function automatic logic [63:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    if (sb == 0 || (sb == -1 && a == 32'h8000_0000)) return 64'hDEAD_BEEF_DEAD_BEEF;
    return {32'(sa % sb), 32'(sa / sb)};
  endfunction

  // Unit models: outputs are junk until exactly N cycles after their reset pulse.
  int m_cnt = MC;
  int d_cnt = DC;
  always @(posedge clk) begin
    if (mult_rst) begin
      m_cnt <= 0; mult_hi <= $urandom; mult_lo <= $urandom;
    end else if (m_cnt < MC) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == MC - 1) {mult_hi, mult_lo} <= ref_mul(unit_a, unit_b);
      else begin mult_hi <= $urandom; mult_lo <= $urandom; end
    end
  end
  always @(posedge clk) begin
    if (div_rst) begin
      d_cnt <= 0; div_hi <= $urandom; div_lo <= $urandom;
    end else if (d_cnt < DC) begin
      d_cnt <= d_cnt + 1;
      if (d_cnt == DC - 1) {div_hi, div_lo} <= ref_div(unit_a, unit_b);
      else begin div_hi <= $urandom; div_lo <= $urandom; end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic drive_noise();
    op_start = 1'($urandom); op_sel = 1'($urandom);
    mthi_we  = 1'($urandom); mtlo_we = 1'($urandom);
    wdata    = $urandom; rs_val = $urandom; rt_val = $urandom;
  endtask

  task automatic clear_inputs();
    op_start = 1'b0; mthi_we = 1'b0; mtlo_we = 1'b0;
  endtask

  // Drivers: one operation, from the start edge to the cycle after commit/exception.
  task automatic do_op(input logic sel, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic noise);
    logic is_exc;
    int   n;
    is_exc = sel && (b == '0);
    n = sel ? DC : MC;
    @(negedge clk);
    op_start = 1'b1; op_sel = sel; rs_val = a; rt_val = b;
    mthi_we = noise; mtlo_we = noise; wdata = $urandom;
    if (!is_exc) exp_q.push_back(sel ? ref_div(a, b) : ref_mul(a, b));
    @(negedge clk);
    clear_inputs();
    rs_val = $urandom; rt_val = $urandom;
    if (is_exc) begin
      check("exc_cycle", {busy, done, div0_exc, mult_rst, div_rst}, 5'b10100);
      @(negedge clk);
      check("exc_after", {busy, div0_exc}, 2'b00);
      check("exc_hilo", {hi_out, lo_out}, {exp_hi, exp_lo});
    end else begin
      check("launch", {busy, done, div0_exc, mult_rst, div_rst}, {3'b100, !sel, sel});
      for (int i = 0; i < n; i++) begin
        @(negedge clk);
        if (noise) drive_noise();
        check("run", {busy, done, div0_exc, mult_rst, div_rst}, 5'b10000);
      end
      @(negedge clk);
      if (noise) drive_noise();
      check("commit", {busy, done, div0_exc, mult_rst, div_rst}, 5'b11000);
      check("operands", {unit_a, unit_b}, {a, b});
      @(negedge clk);
      clear_inputs();
      {exp_hi, exp_lo} = exp_q.pop_front();
      check("result", {hi_out, lo_out}, {exp_hi, exp_lo});
      check("idle", {busy, done}, 2'b00);
    end
  endtask

  task automatic mt_write(input logic we_hi, input logic we_lo, input logic [W-1:0] d);
    @(negedge clk);
    mthi_we = we_hi; mtlo_we = we_lo; wdata = d;
    @(negedge clk);
    clear_inputs();
    if (we_hi) exp_hi = d;
    if (we_lo) exp_lo = d;
    check("mt_hilo", {hi_out, lo_out}, {exp_hi, exp_lo});
    check("mt_busy", busy, 1'b0);
  endtask

  task automatic abort_test();
    @(negedge clk);
    op_start = 1'b1; op_sel = 1'b0; rs_val = 32'd5; rt_val = 32'd9;
    @(negedge clk);
    clear_inputs();
    repeat (10) @(negedge clk);
    check("pre_abort_busy", busy, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("abort_regs", {hi_out, lo_out}, 64'd0);
    check("abort_ops", {unit_a, unit_b}, 64'd0);
    check("abort_ctl", {busy, done, div0_exc, mult_rst, div_rst}, 5'b00011);
    exp_hi = '0; exp_lo = '0;
    @(negedge clk);
    reset = 1'b0;
    do_op(1'b0, 32'd2, 32'd3, 1'b0);
    check("abort_then_mult", {hi_out, lo_out}, {32'd0, 32'd6});
  endtask

  initial begin
    logic [W-1:0] a, b;
    repeat (2) @(negedge clk);
    check("rst_regs", {hi_out, lo_out, unit_a, unit_b}, 128'd0);
    check("rst_ctl", {busy, done, div0_exc, mult_rst, div_rst}, 5'b00011);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst", {busy, mult_rst, div_rst}, 3'b000);

    do_op(1'b0, 32'd7, 32'hFFFF_FFFD, 1'b0);
    check("mult_7x-3", {hi_out, lo_out}, {32'hFFFF_FFFF, 32'hFFFF_FFEB});
    do_op(1'b1, 32'd100, 32'd7, 1'b0);
    check("div_100/7", {hi_out, lo_out}, {32'd2, 32'd14});
    mt_write(1'b1, 1'b0, 32'hA5A5_A5A5);
    do_op(1'b1, 32'd55, 32'd0, 1'b0);
    check("div0_hi", hi_out, 32'hA5A5_A5A5);
    do_op(1'b0, $urandom, $urandom, 1'b1);
    mt_write(1'b1, 1'b1, 32'h1234_5678);
    check("mt_both", {hi_out, lo_out}, {32'h1234_5678, 32'h1234_5678});
    abort_test();

    for (int t = 0; t < 25; t++) begin
      a = $urandom;
      b = $urandom;
      if (b == 32'hFFFF_FFFF) b = 32'd5;
      case ($urandom_range(0, 4))
        0: mt_write(1'($urandom), 1'($urandom), $urandom);
        1: do_op(1'b1, a, 32'd0, 1'($urandom));
        2: do_op(1'b1, a, 32'($urandom_range(1, 1000)), 1'($urandom));
        3: do_op(1'b1, a, b, 1'($urandom));
        default: do_op(1'b0, a, b, 1'($urandom));
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
